hd_temporal_ngram_encoder: RTL and testbench
============================================

// Module: hd_temporal_ngram_encoder
// PURPOSE
//  Temporal N-gram encoder for the three sensor modalities. Sits directly upstream of the associative memory:
//  - consumes one spatially-encoded hypervector per modality per sample;
//  - binds it with permuted copies of that modality's previous NGRAM-1 samples;
//  - hands the three N-gram hypervectors to the AM over a valid/ready handshake (AM majority-votes them).
// PARAMETERS
//  HV_DIM   `HV_DIMENSION (2000)  hypervector width in bits, index order [0:HV_DIM-1]
//  NGRAM    3                     N-gram length; legal range 1..8
// PORTS
//  Clk_CI                   in   1       clock; single clock domain
//  Rst_RBI                  in   1       reset; asynchronous, active-low
//  Clear_SI                 in   1       sync clear of history/fill count (new recording window)
//  ValidIn_SI               in   1       upstream sample valid
//  ReadyOut_SO              out  1       block can accept a sample
//  HypervectorIn_mod1_DI    in   HV_DIM  spatial HV, modality 1 (mod2, mod3 identical)
//  HypervectorIn_mod2_DI    in   HV_DIM
//  HypervectorIn_mod3_DI    in   HV_DIM
//  ValidOut_SO              out  1       N-gram outputs valid
//  ReadyIn_SI               in   1       downstream (AM) ready
//  HypervectorOut_mod1_DO   out  HV_DIM  N-gram HV, modality 1 (mod2, mod3 identical)
//  HypervectorOut_mod2_DO   out  HV_DIM
//  HypervectorOut_mod3_DO   out  HV_DIM
// BEHAVIOUR
//  - Reset (Rst_RBI=0, async): FSM=IDLE, fill count=0, all history regs=0, all HypervectorOut_*=0, ValidOut_SO=0.
//  - rho(x) = 1-bit circular rotate toward higher index: rho(x)[i+1]=x[i], rho(x)[0]=x[HV_DIM-1]. rho^k = k rotations.
//  - Per modality, history H[0..NGRAM-2], where H[0] is the newest previous sample.
//  - N-gram = x ^ rho(H[0]) ^ rho^2(H[1]) ^ ... ^ rho^(NGRAM-1)(H[NGRAM-2]); pure bitwise, no carries.
//  - Fill counter: width ceilLog2(NGRAM); saturates at NGRAM-1.
//  - FSM states:
//    IDLE: ReadyOut_SO=1, ValidOut_SO=0. Accept = ValidIn_SI & ReadyOut_SO. On accept:
//      history shifts (H[k]<=H[k-1], H[0]<=x), all modalities together.
//      If fill count < NGRAM-1: increment, stay IDLE, no output (warm-up).
//      Else: register N-gram (computed from pre-shift history) into outputs; go OUTPUT_STABLE.
//    OUTPUT_STABLE: ValidOut_SO=1, ReadyOut_SO=0, outputs held stable.
//      ReadyIn_SI=1 -> IDLE next cycle; else stay.
//  - Latency: accept in cycle t -> ValidOut_SO=1 in cycle t+1. Max throughput: 1 sample per 2 cycles.
//  - Warm-up: after reset or Clear_SI, the first NGRAM-1 accepted samples produce no output. NGRAM=1: no history, output=input, no warm-up.
//  - Clear_SI=1 (sync): next cycle FSM=IDLE, fill=0, history=0, ValidOut_SO=0; HypervectorOut_* retain value.
//    Clear beats a simultaneous accept (sample dropped) and a pending output (transfer aborted).
//  - Rst_RBI asserted mid-operation: immediate return to reset values, pending output lost.
//  - ValidIn_SI while in OUTPUT_STABLE: ignored (ReadyOut_SO=0); upstream must hold its data.
// TESTING (HV_DIM=8, NGRAM=3 unless stated; hex shown MSB=index 0)
//  - Reset: hold Rst_RBI=0 mid-stream -> ValidOut_SO=0, outputs 8'h00 immediately; first 2 samples after release give no output.
//  - Basic: mod1 samples 80,80,80 -> only 3rd gives ValidOut, out=E0; a 4th sample 00 -> out=60.
//  - Wrap: mod1 samples 01,01,01 -> out=C1 (rotation wraps index 7 to 0); mod2/mod3 driven independently give independent results.
//  - Backpressure: ReadyIn_SI=0 for 5 cycles after valid -> ValidOut_SO stays 1, out unchanged, ReadyOut_SO=0;
//    ValidIn_SI held meanwhile is not accepted until 1 cycle after ReadyIn_SI=1.
//  - Clear: Clear_SI during OUTPUT_STABLE -> ValidOut_SO=0 next cycle; next sample 80 gives no output (warm-up restarts).
//  - NGRAM=1: sample A5 -> ValidOut next cycle, out=A5; back-to-back samples with ReadyIn_SI=1 -> one output per 2 cycles.

Source files
------------

// File: rtl/hd_temporal_ngram_encoder.sv
// Temporal N-gram encoder: binds each modality's current spatial hypervector with
// rotated copies of its previous NGRAM-1 samples and hands the result to the AM.
module hd_temporal_ngram_encoder #(
    parameter int HV_DIM = 2000,
    parameter int NGRAM  = 3
) (
    input  logic              Clk_CI,
    input  logic              Rst_RBI,
    input  logic              Clear_SI,
    input  logic              ValidIn_SI,
    output logic              ReadyOut_SO,
    input  logic [0:HV_DIM-1] HypervectorIn_mod1_DI,
    input  logic [0:HV_DIM-1] HypervectorIn_mod2_DI,
    input  logic [0:HV_DIM-1] HypervectorIn_mod3_DI,
    output logic              ValidOut_SO,
    input  logic              ReadyIn_SI,
    output logic [0:HV_DIM-1] HypervectorOut_mod1_DO,
    output logic [0:HV_DIM-1] HypervectorOut_mod2_DO,
    output logic [0:HV_DIM-1] HypervectorOut_mod3_DO,
    output logic              DbgState_SO
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // the sender holds data stable while valid is 1 and ready is 0.

    localparam int HIST = (NGRAM > 1) ? NGRAM - 1 : 1;
    localparam int FW   = (NGRAM > 1) ? $clog2(NGRAM) : 1;

    typedef enum logic {
        IDLE          = 1'b0,
        OUTPUT_STABLE = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [FW-1:0]     fill_q, fill_d;
    logic [0:HV_DIM-1] hist_q [3][HIST];
    logic [0:HV_DIM-1] hist_d [3][HIST];
    logic [0:HV_DIM-1] out_q  [3];
    logic [0:HV_DIM-1] out_d  [3];
    logic [0:HV_DIM-1] x      [3];
    logic [0:HV_DIM-1] ngram  [3];
    logic [0:HV_DIM-1] rot;
    logic              accept;

    // One step toward higher index; index HV_DIM-1 wraps to index 0.
    function automatic logic [0:HV_DIM-1] rho(input logic [0:HV_DIM-1] v);
        rho = {v[HV_DIM-1], v[0:HV_DIM-2]};
    endfunction

    always_comb begin
        x[0]        = HypervectorIn_mod1_DI;
        x[1]        = HypervectorIn_mod2_DI;
        x[2]        = HypervectorIn_mod3_DI;
        ReadyOut_SO = (state_q == IDLE);
        ValidOut_SO = (state_q == OUTPUT_STABLE);
        accept      = ValidIn_SI & ReadyOut_SO;
        state_d     = state_q;
        fill_d      = fill_q;
        hist_d      = hist_q;
        out_d       = out_q;
        rot         = '0;

        // N-gram uses the history as it was before this sample shifts in.
        for (int m = 0; m < 3; m++) begin
            ngram[m] = x[m];
            for (int k = 0; k < NGRAM - 1; k++) begin
                rot = hist_q[m][k];
                for (int j = 0; j <= k; j++) rot = rho(rot);
                ngram[m] = ngram[m] ^ rot;
            end
        end

        if (Clear_SI) begin
            state_d = IDLE;
            fill_d  = '0;
            for (int m = 0; m < 3; m++)
                for (int k = 0; k < HIST; k++) hist_d[m][k] = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        for (int m = 0; m < 3; m++) begin
                            hist_d[m][0] = x[m];
                            for (int k = 1; k < HIST; k++) hist_d[m][k] = hist_q[m][k-1];
                        end
                        if (fill_q < FW'(NGRAM - 1)) begin
                            fill_d = fill_q + FW'(1);
                        end else begin
                            out_d   = ngram;
                            state_d = OUTPUT_STABLE;
                        end
                    end
                end
                OUTPUT_STABLE: begin
                    if (ReadyIn_SI) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q <= IDLE;
            fill_q  <= '0;
            for (int m = 0; m < 3; m++) begin
                out_q[m] <= '0;
                for (int k = 0; k < HIST; k++) hist_q[m][k] <= '0;
            end
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            hist_q  <= hist_d;
            out_q   <= out_d;
        end
    end

    assign HypervectorOut_mod1_DO = out_q[0];
    assign HypervectorOut_mod2_DO = out_q[1];
    assign HypervectorOut_mod3_DO = out_q[2];
    assign DbgState_SO            = logic'(state_q);

endmodule

// File: tb/tb_hd_temporal_ngram_encoder.sv
// Directed bench for the temporal N-gram encoder at HV_DIM=8, with NGRAM=3 and NGRAM=1 instances.
module tb_hd_temporal_ngram_encoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0, vin = 1'b0, rdy_in = 1'b1;
    logic [0:7] in1 = '0, in2 = '0, in3 = '0;
    logic       rdy_out, vout, dbg;
    logic [0:7] out1, out2, out3;

    logic       clr_b = 1'b0, vin_b = 1'b0, rdy_in_b = 1'b1;
    logic [0:7] in_b = '0;
    logic       rdy_out_b, vout_b, dbg_b;
    logic [0:7] out1_b, out2_b, out3_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hd_temporal_ngram_encoder #(.HV_DIM(8), .NGRAM(3)) u_dut (
        .Clk_CI(clk), .Rst_RBI(rst_n), .Clear_SI(clr), .ValidIn_SI(vin), .ReadyOut_SO(rdy_out),
        .HypervectorIn_mod1_DI(in1), .HypervectorIn_mod2_DI(in2), .HypervectorIn_mod3_DI(in3),
        .ValidOut_SO(vout), .ReadyIn_SI(rdy_in),
        .HypervectorOut_mod1_DO(out1), .HypervectorOut_mod2_DO(out2), .HypervectorOut_mod3_DO(out3),
        .DbgState_SO(dbg)
    );

    hd_temporal_ngram_encoder #(.HV_DIM(8), .NGRAM(1)) u_dut1 (
        .Clk_CI(clk), .Rst_RBI(rst_n), .Clear_SI(clr_b), .ValidIn_SI(vin_b), .ReadyOut_SO(rdy_out_b),
        .HypervectorIn_mod1_DI(in_b), .HypervectorIn_mod2_DI(8'h00), .HypervectorIn_mod3_DI(8'hFF),
        .ValidOut_SO(vout_b), .ReadyIn_SI(rdy_in_b),
        .HypervectorOut_mod1_DO(out1_b), .HypervectorOut_mod2_DO(out2_b), .HypervectorOut_mod3_DO(out3_b),
        .DbgState_SO(dbg_b)
    );

    typedef struct {
        logic       valid;
        logic       ready_in;
        logic [7:0] i1, i2, i3;
        logic       exp_valid;
        logic       exp_ready;
        logic [7:0] e1, e2, e3;
    } vec_t;

    vec_t vecs [6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string name, input logic [7:0] e1, input logic [7:0] e2,
                            input logic [7:0] e3);
        chk({name, ".out1"}, 32'(out1), 32'(e1));
        chk({name, ".out2"}, 32'(out2), 32'(e2));
        chk({name, ".out3"}, 32'(out3), 32'(e3));
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input logic ri);
        vin = 1'b1; in1 = a; in2 = b; in3 = c; rdy_in = ri;
        step();
        vin = 1'b0;
    endtask

    initial begin
        // mod1: 80,80,80 then 00; mod2: 01,01,01 then 00; mod3: 00,00,FF then 00
        vecs[0] = '{1'b1, 1'b1, 8'h80, 8'h01, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00};
        vecs[1] = '{1'b1, 1'b1, 8'h80, 8'h01, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00};
        vecs[2] = '{1'b1, 1'b1, 8'h80, 8'h01, 8'hFF, 1'b1, 1'b0, 8'hE0, 8'hC1, 8'hFF};
        vecs[3] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'hE0, 8'hC1, 8'hFF};
        vecs[4] = '{1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h60, 8'hC0, 8'hFF};
        vecs[5] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h60, 8'hC0, 8'hFF};

        // Reset state
        step(); step();
        chk("rst.vout", 32'(vout), 32'd0);
        chk("rst.rdy_out", 32'(rdy_out), 32'd1);
        chk("rst.state", 32'(dbg), 32'd0);
        chk_outs("rst", 8'h00, 8'h00, 8'h00);
        rst_n = 1'b1;

        // Table: warm-up, basic, wrap, independent modalities
        foreach (vecs[i]) begin
            vin = vecs[i].valid; rdy_in = vecs[i].ready_in;
            in1 = vecs[i].i1; in2 = vecs[i].i2; in3 = vecs[i].i3;
            step();
            chk($sformatf("vec%0d.vout", i), 32'(vout), 32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d.rdy_out", i), 32'(rdy_out), 32'(vecs[i].exp_ready));
            chk_outs($sformatf("vec%0d", i), vecs[i].e1, vecs[i].e2, vecs[i].e3);
        end

        // Backpressure: history mod1 H0=00,H1=80; mod2 H0=00,H1=01; mod3 H0=00,H1=FF
        send(8'h80, 8'h00, 8'h00, 1'b0);
        chk("bp.vout0", 32'(vout), 32'd1);
        chk_outs("bp.first", 8'hA0, 8'h40, 8'hFF);
        vin = 1'b1; in1 = 8'h00; in2 = 8'h00; in3 = 8'h00;
        for (int c = 0; c < 5; c++) begin
            step();
            chk($sformatf("bp.hold%0d.vout", c), 32'(vout), 32'd1);
            chk($sformatf("bp.hold%0d.rdy_out", c), 32'(rdy_out), 32'd0);
            chk($sformatf("bp.hold%0d.out1", c), 32'(out1), 32'h A0);
        end
        rdy_in = 1'b1;
        step();
        chk("bp.release.vout", 32'(vout), 32'd0);
        chk("bp.release.rdy_out", 32'(rdy_out), 32'd1);
        step();
        vin = 1'b0;
        chk("bp.accept.vout", 32'(vout), 32'd1);
        chk_outs("bp.accept", 8'h40, 8'h00, 8'h00);
        step();

        // Clear during OUTPUT_STABLE, with a simultaneous valid sample that must be dropped
        send(8'h00, 8'h00, 8'h00, 1'b0);
        chk("clr.pre.vout", 32'(vout), 32'd1);
        chk("clr.pre.out1", 32'(out1), 32'h20);
        clr = 1'b1; vin = 1'b1; in1 = 8'h80;
        step();
        clr = 1'b0; vin = 1'b0; rdy_in = 1'b1;
        chk("clr.vout", 32'(vout), 32'd0);
        chk("clr.state", 32'(dbg), 32'd0);
        chk("clr.out1_kept", 32'(out1), 32'h20);
        send(8'h80, 8'h00, 8'h00, 1'b1);
        chk("clr.warm1.vout", 32'(vout), 32'd0);
        send(8'h80, 8'h00, 8'h00, 1'b1);
        chk("clr.warm2.vout", 32'(vout), 32'd0);
        send(8'h80, 8'h00, 8'h00, 1'b0);
        chk("clr.third.vout", 32'(vout), 32'd1);
        chk("clr.third.out1", 32'(out1), 32'hE0);

        // Asynchronous reset while an output is pending
        rst_n = 1'b0;
        #1;
        chk("arst.vout", 32'(vout), 32'd0);
        chk("arst.rdy_out", 32'(rdy_out), 32'd1);
        chk_outs("arst", 8'h00, 8'h00, 8'h00);
        #2 rst_n = 1'b1;
        rdy_in = 1'b1;
        send(8'h80, 8'h00, 8'h00, 1'b1);
        chk("arst.warm1.vout", 32'(vout), 32'd0);
        send(8'h80, 8'h00, 8'h00, 1'b1);
        chk("arst.warm2.vout", 32'(vout), 32'd0);
        send(8'h80, 8'h00, 8'h00, 1'b1);
        chk("arst.third.vout", 32'(vout), 32'd1);
        chk("arst.third.out1", 32'(out1), 32'hE0);
        step();

        // NGRAM=1: no warm-up, output equals input, one output every 2 cycles
        vin_b = 1'b1; in_b = 8'hA5; rdy_in_b = 1'b1;
        step();
        chk("n1.first.vout", 32'(vout_b), 32'd1);
        chk("n1.first.out1", 32'(out1_b), 32'hA5);
        chk("n1.first.out2", 32'(out2_b), 32'h00);
        chk("n1.first.out3", 32'(out3_b), 32'hFF);
        in_b = 8'h3C;
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("n1.b2b%0d.vout", c), 32'(vout_b), 32'(c % 2));
            chk($sformatf("n1.b2b%0d.out1", c), 32'(out1_b), (c == 0) ? 32'hA5 : 32'h3C);
        end
        vin_b = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
